line_request_scheduler: RTL and testbench

Shares one line drawer (start/done/ready handshake, 9-bit x, 8-bit y, 3-bit colour) between NUM_REQ independent requesters, such as a clear-screen engine, a shape generator and a user-input path. Arbitration is round-robin. The block latches the granted line command, sequences the drawer's start/done handshake, and reports per-requester completion. A watchdog aborts a draw that never completes.

---
 rtl/lda_pkg.sv | 30 +++
 rtl/rr_priority_pick.sv | 36 +++
 rtl/line_request_scheduler.sv | 161 ++++++++++++++++
 tb/tb_line_request_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lda_pkg.sv
// Shared types and widths for the line drawer scheduler: the latched line
// command, the scheduler state encoding and the round-robin pointer helper.
package lda_pkg;

   localparam int X_W  = 9;
   localparam int Y_W  = 8;
   localparam int C_W  = 3;
   localparam int ID_W = 3;   // requester index width, up to 8 requesters

   // Field order matches the drawer's own colour/x0/y0/x1/y1 bundle.
   typedef struct packed {
      logic [C_W-1:0] colour;
      logic [X_W-1:0] x0;
      logic [Y_W-1:0] y0;
      logic [X_W-1:0] x1;
      logic [Y_W-1:0] y1;
   } line_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      DRAW,
      RELEASE
   } sched_state_t;

   // Requester after 'id' in round-robin order, wrapping at n-1.
   function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id, input int n);
      return (id == ID_W'(n - 1)) ? '0 : id + ID_W'(1);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: returns the first asserted request found when scanning
// from rr_ptr upward, wrapping modulo NUM_REQ. Purely combinational.
module rr_priority_pick
   import lda_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               valid,
   output logic [ID_W-1:0]    idx
);

   localparam int SW = ID_W + 1;

   logic [2*NUM_REQ-1:0] req_rot;
   logic [ID_W-1:0]      offset;
   logic [SW-1:0]        sum;

   // Rotate so the highest-priority requester sits at bit 0, take the lowest
   // set bit, then map the offset back to an absolute index.
   // NOTE: every output of an always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      valid   = |req;
      offset  = '0;
      req_rot = {req, req} >> rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) offset = ID_W'(k);
      end
      sum = {1'b0, rr_ptr} + {1'b0, offset};
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = sum[ID_W-1:0];
   end

endmodule

// File: rtl/line_request_scheduler.sv
// Shares one line drawer between NUM_REQ requesters. Round-robin grant in
// IDLE, holds the drawer start through DRAW under a watchdog, then waits in
// RELEASE for the drawer to return to ready before granting again.
module line_request_scheduler
   import lda_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 131072
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [C_W*NUM_REQ-1:0] req_colour,
   input  logic [X_W*NUM_REQ-1:0] req_x0,
   input  logic [Y_W*NUM_REQ-1:0] req_y0,
   input  logic [X_W*NUM_REQ-1:0] req_x1,
   input  logic [Y_W*NUM_REQ-1:0] req_y1,
   output logic [NUM_REQ-1:0]     ack,
   output logic [NUM_REQ-1:0]     line_done,
   output logic                   timeout,
   output logic [ID_W-1:0]        active_id,
   output logic                   busy,
   output logic                   lda_start,
   output logic [C_W-1:0]         lda_colour,
   output logic [X_W-1:0]         lda_x0,
   output logic [Y_W-1:0]         lda_y0,
   output logic [X_W-1:0]         lda_x1,
   output logic [Y_W-1:0]         lda_y1,
   input  logic                   lda_done,
   input  logic                   lda_ready
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   sched_state_t         state_q;
   logic [ID_W-1:0]      rr_ptr_q;
   logic [ID_W-1:0]      active_id_q;
   logic [WD_W-1:0]      wd_q;
   line_cmd_t            cmd_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic [NUM_REQ-1:0]   line_done_q;
   logic                 timeout_q;
   logic                 busy_q;
   logic                 lda_start_q;

   logic                 pick_valid;
   logic [ID_W-1:0]      pick_idx;
   logic                 grant_d;
   line_cmd_t            cmd_d;
   logic [NUM_REQ-1:0]   ack_d;
   logic [NUM_REQ-1:0]   line_done_d;
   logic [ID_W-1:0]      rr_ptr_d;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .valid  (pick_valid),
      .idx    (pick_idx)
   );

   // Select the winner's command and build the one-hot ack/done vectors.
   always_comb begin
      cmd_d       = '0;
      ack_d       = '0;
      line_done_d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == ID_W'(i)) begin
            cmd_d = '{colour: req_colour[C_W*i +: C_W],
                      x0:     req_x0[X_W*i +: X_W],
                      y0:     req_y0[Y_W*i +: Y_W],
                      x1:     req_x1[X_W*i +: X_W],
                      y1:     req_y1[Y_W*i +: Y_W]};
         end
         ack_d[i]       = (pick_idx == ID_W'(i));
         line_done_d[i] = (active_id_q == ID_W'(i));
      end
   end

   // A grant needs a quiet, ready drawer and at least one request.
   assign grant_d  = lda_ready && !lda_done && pick_valid;
   assign rr_ptr_d = rr_next(active_id_q, NUM_REQ);

   // Scheduler FSM with all outputs registered; pulses self-clear each cycle.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         active_id_q <= '0;
         wd_q        <= '0;
         cmd_q       <= '0;
         ack_q       <= '0;
         line_done_q <= '0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
         lda_start_q <= 1'b0;
      end else begin
         ack_q       <= '0;
         line_done_q <= '0;
         timeout_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  cmd_q       <= cmd_d;
                  active_id_q <= pick_idx;
                  ack_q       <= ack_d;
                  busy_q      <= 1'b1;
                  lda_start_q <= 1'b1;
                  wd_q        <= '0;
                  state_q     <= DRAW;
               end
            end
            DRAW: begin
               // A done on the watchdog's last cycle still counts as normal.
               if (lda_done) begin
                  lda_start_q <= 1'b0;
                  line_done_q <= line_done_d;
                  rr_ptr_q    <= rr_ptr_d;
                  state_q     <= RELEASE;
               end else if (wd_q == WD_LAST) begin
                  lda_start_q <= 1'b0;
                  timeout_q   <= 1'b1;
                  rr_ptr_q    <= rr_ptr_d;
                  state_q     <= RELEASE;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            RELEASE: begin
               // Wait out the drawer's done/ready handshake; no grant here.
               if (!lda_done && lda_ready) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               busy_q      <= 1'b0;
               lda_start_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign ack        = ack_q;
   assign line_done  = line_done_q;
   assign timeout    = timeout_q;
   assign active_id  = active_id_q;
   assign busy       = busy_q;
   assign lda_start  = lda_start_q;
   assign lda_colour = cmd_q.colour;
   assign lda_x0     = cmd_q.x0;
   assign lda_y0     = cmd_q.y0;
   assign lda_x1     = cmd_q.x1;
   assign lda_y1     = cmd_q.y1;

endmodule

// File: tb/tb_line_request_scheduler.sv
// Directed bench for line_request_scheduler with a behavioural line drawer
// and a grant/done scoreboard filled as stimulus is applied.
module tb_line_request_scheduler;
   import lda_pkg::*;

   localparam int NR = 4;
   localparam int TO = 100;
   localparam int DD = 12;

   typedef struct {
      int        id;
      line_cmd_t cmd;
   } grant_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req;
   logic [3*NR-1:0]   req_colour;
   logic [9*NR-1:0]   req_x0, req_x1;
   logic [8*NR-1:0]   req_y0, req_y1;
   logic [NR-1:0]     ack, line_done;
   logic              timeout, busy, lda_start;
   logic [2:0]        active_id, lda_colour;
   logic [8:0]        lda_x0, lda_x1;
   logic [7:0]        lda_y0, lda_y1;
   logic              lda_done, lda_ready;

   int checks = 0, failures = 0;
   int ack_cnt = 0, done_cnt = 0, to_cnt = 0;
   int done_delay = DD;
   bit done_never = 1'b0;
   bit ready_en = 1'b1;
   line_cmd_t cmds [NR];
   grant_t    exp_grant_q [$];
   int        exp_done_q [$];

   always #5 clk = ~clk;

   line_request_scheduler #(
      .NUM_REQ        (NR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_colour (req_colour),
      .req_x0     (req_x0),
      .req_y0     (req_y0),
      .req_x1     (req_x1),
      .req_y1     (req_y1),
      .ack        (ack),
      .line_done  (line_done),
      .timeout    (timeout),
      .active_id  (active_id),
      .busy       (busy),
      .lda_start  (lda_start),
      .lda_colour (lda_colour),
      .lda_x0     (lda_x0),
      .lda_y0     (lda_y0),
      .lda_x1     (lda_x1),
      .lda_y1     (lda_y1),
      .lda_done   (lda_done),
      .lda_ready  (lda_ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int i, input logic [2:0] c, input logic [8:0] x0,
                          input logic [7:0] y0, input logic [8:0] x1, input logic [7:0] y1);
      cmds[i] = '{colour: c, x0: x0, y0: y0, x1: x1, y1: y1};
      req_colour[3*i +: 3] = c;
      req_x0[9*i +: 9]     = x0;
      req_y0[8*i +: 8]     = y0;
      req_x1[9*i +: 9]     = x1;
      req_y1[8*i +: 8]     = y1;
   endtask

   task automatic push_grant(input int id);
      grant_t g;
      g.id  = id;
      g.cmd = cmds[id];
      exp_grant_q.push_back(g);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_ack(input int target, input int budget);
      int n = 0;
      while (ack_cnt < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wait_ack", 64'(ack_cnt >= target), 64'(1));
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wait_done", 64'(done_cnt >= target), 64'(1));
   endtask

   task automatic wait_timeout(input int target, input int budget);
      int n = 0;
      while (to_cnt < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wait_timeout", 64'(to_cnt >= target), 64'(1));
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wait_idle", 64'(busy), 64'(0));
   endtask

   // Behavioural drawer: done after done_delay cycles of start, held until
   // start drops; ready only while idle and enabled.
   initial begin
      int cnt = 0;
      lda_done  = 1'b0;
      lda_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!lda_start) begin
            lda_done = 1'b0;
            cnt      = 0;
         end else if (!lda_done) begin
            cnt++;
            if (!done_never && cnt >= done_delay) lda_done = 1'b1;
         end
         lda_ready = ready_en && !lda_start && !lda_done;
      end
   end

   // Output monitor: pops the scoreboard on every ack and line_done pulse.
   initial begin
      logic [NR-1:0] prev_ack = '0;
      logic          prev_busy = 1'b0;
      int            run = 0;
      grant_t        g;
      int            id;
      forever begin
         @(negedge clk);
         if (ack != '0) begin
            check("ack_onehot", 64'($onehot(ack)), 64'(1));
            check("ack_single_cycle", 64'(ack & prev_ack), 64'(0));
            check("ack_while_busy", 64'(prev_busy), 64'(0));
            if (exp_grant_q.size() == 0) begin
               check("ack_unexpected", 64'(ack), 64'(0));
            end else begin
               g = exp_grant_q.pop_front();
               check("grant_id", 64'(active_id), 64'(g.id));
               check("grant_ack_vec", 64'(ack), 64'(1) << g.id);
               check("grant_cmd", 64'({lda_colour, lda_x0, lda_y0, lda_x1, lda_y1}), 64'(g.cmd));
               check("grant_busy_start", 64'({busy, lda_start}), 64'(2'b11));
            end
            ack_cnt++;
         end
         if (line_done != '0) begin
            if (exp_done_q.size() == 0) begin
               check("done_unexpected", 64'(line_done), 64'(0));
            end else begin
               id = exp_done_q.pop_front();
               check("done_vec", 64'(line_done), 64'(1) << id);
               check("done_start_low", 64'(lda_start), 64'(0));
               check("done_start_run", 64'(run), 64'(done_delay));
            end
            done_cnt++;
         end
         if (timeout) begin
            check("timeout_start_run", 64'(run), 64'(TO));
            check("timeout_no_done", 64'({line_done, lda_start}), 64'(0));
            to_cnt++;
         end
         run       = lda_start ? run + 1 : 0;
         prev_ack  = ack;
         prev_busy = busy;
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int base_ack, base_done;
      rst        = 1'b1;
      req        = '0;
      req_colour = '0;
      req_x0     = '0;
      req_y0     = '0;
      req_x1     = '0;
      req_y1     = '0;
      for (int i = 0; i < NR; i++)
         set_cmd(i, 3'(i + 1), 9'(i * 20 + 7), 8'(i * 10 + 3), 9'(i * 20 + 50), 8'(i * 10 + 30));
      #1;
      check("rst_pulses", 64'({ack, line_done, timeout}), 64'(0));
      check("rst_busy_start", 64'({busy, lda_start}), 64'(0));
      check("rst_active_id", 64'(active_id), 64'(0));
      check("rst_cmd", 64'({lda_colour, lda_x0, lda_y0, lda_x1, lda_y1}), 64'(0));
      cycles(3);
      rst = 1'b0;

      // Single line from requester 0, one-cycle grant latency.
      set_cmd(0, 3'b100, 9'd0, 8'd0, 9'd10, 8'd5);
      push_grant(0);
      exp_done_q.push_back(0);
      cycles(1);
      req = 4'b0001;
      cycles(1);
      check("t1_ack_latency", 64'(ack), 64'(4'b0001));
      check("t1_start", 64'(lda_start), 64'(1));
      check("t1_x1_y1", 64'({lda_x1, lda_y1}), 64'({9'd10, 8'd5}));
      req = '0;
      wait_done(1, 60);
      check("t1_busy_in_release", 64'(busy), 64'(1));
      wait_idle(20);
      check("t1_idle_start", 64'(lda_start), 64'(0));

      // Fairness from reset with all requesters held.
      rst = 1'b1;
      req = 4'b1111;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NR; i++) begin
            push_grant(i);
            exp_done_q.push_back(i);
         end
      base_ack  = ack_cnt;
      base_done = done_cnt;
      cycles(2);
      rst = 1'b0;
      wait_ack(base_ack + 8, 400);
      req = '0;
      wait_done(base_done + 8, 400);
      wait_idle(20);

      // Pointer: after requester 2 finishes, 0 beats 2.
      push_grant(2);
      exp_done_q.push_back(2);
      base_ack  = ack_cnt;
      base_done = done_cnt;
      req = 4'b0100;
      wait_ack(base_ack + 1, 20);
      req = '0;
      wait_done(base_done + 1, 60);
      wait_idle(20);
      push_grant(0);
      push_grant(2);
      exp_done_q.push_back(0);
      exp_done_q.push_back(2);
      req = 4'b0101;
      wait_ack(base_ack + 2, 20);
      check("t3_first_winner", 64'(active_id), 64'(0));
      req[0] = 1'b0;
      wait_ack(base_ack + 3, 60);
      check("t3_second_winner", 64'(active_id), 64'(2));
      req[2] = 1'b0;
      wait_done(base_done + 3, 60);
      wait_idle(20);

      // Watchdog: pointer is at 3, drawer never finishes that draw.
      done_never = 1'b1;
      push_grant(3);
      push_grant(1);
      exp_done_q.push_back(1);
      base_ack  = ack_cnt;
      base_done = done_cnt;
      req = 4'b1010;
      wait_ack(base_ack + 1, 20);
      check("t4_stuck_owner", 64'(active_id), 64'(3));
      req[3] = 1'b0;
      wait_timeout(1, 150);
      check("t4_no_done_on_timeout", 64'(done_cnt), 64'(base_done));
      done_never = 1'b0;
      wait_ack(base_ack + 2, 20);
      check("t4_next_owner", 64'(active_id), 64'(1));
      req = '0;
      wait_done(base_done + 1, 60);
      wait_idle(20);

      // Reset while ack is high, then a gated re-grant.
      push_grant(0);
      base_ack = ack_cnt;
      req = 4'b0001;
      wait_ack(base_ack + 1, 20);
      req      = '0;
      ready_en = 1'b0;
      rst      = 1'b1;
      #1;
      check("t5_rst_ack", 64'(ack), 64'(0));
      check("t5_rst_busy_start", 64'({busy, lda_start}), 64'(0));
      check("t5_rst_cmd", 64'({lda_colour, lda_x0, lda_y0, lda_x1, lda_y1}), 64'(0));
      cycles(2);
      rst = 1'b0;
      req = 4'b0010;
      base_ack  = ack_cnt;
      base_done = done_cnt;
      cycles(10);
      check("t5_ready_gate", 64'(ack_cnt), 64'(base_ack));
      check("t5_ready_gate_busy", 64'(busy), 64'(0));
      push_grant(1);
      exp_done_q.push_back(1);
      ready_en = 1'b1;
      wait_ack(base_ack + 1, 20);
      check("t5_regrant_owner", 64'(active_id), 64'(1));
      req = '0;
      wait_done(base_done + 1, 60);
      wait_idle(20);

      // Withdrawn request while the drawer is not ready.
      ready_en = 1'b0;
      cycles(2);
      base_ack = ack_cnt;
      req = 4'b1000;
      cycles(3);
      req = '0;
      cycles(2);
      ready_en = 1'b1;
      cycles(10);
      check("t6_withdraw_no_ack", 64'(ack_cnt), 64'(base_ack));
      check("t6_withdraw_idle", 64'({busy, lda_start}), 64'(0));

      check("grant_queue_drained", 64'(exp_grant_q.size()), 64'(0));
      check("done_queue_drained", 64'(exp_done_q.size()), 64'(0));
      check("timeout_count", 64'(to_cnt), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
